// File: rtl/somador_serial.sv
// somador_serial: digit-serial adder.
// Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, LSB first.
// Result registers only change on the edge that processes the last slice, so
// soma/cout/overflow always hold the last completed operation.
//
// Parameters:
//   WIDTH     operand/result width in bits (>= 2)
//   DIGIT     bits added per clock; WIDTH must be a multiple of DIGIT
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request a new addition (accepted in IDLE or FIM)
//   a, b, cin operands, sampled only on the accepting edge
//   soma      registered sum of last completed operation
//   cout      registered unsigned carry-out
//   overflow  registered two's-complement overflow
//   busy      high while in SOMA
//   done      one-cycle pulse (state FIM) when the result registers update
//
// state | meaning
// IDLE  | waiting for start
// SOMA  | adding one DIGIT-bit slice per edge
// FIM   | result just updated; done high; may accept a new start
module somador_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] soma,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOMA = 2'd1,
        FIM  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   soma_q, soma_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DIGIT:0]     slice_sum;
    logic               last_slice;
    logic [WIDTH-1:0]   acc_shifted;

    // a_q/b_q shift right each slice, so the current slice always sits in the
    // low DIGIT bits. On the last slice those bits hold the operand MSBs.
    always_comb begin
        slice_sum   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
        last_slice  = (cnt_q == CNT_W'(N - 1));
        // Partial sum fills from the top; after N slices it is fully aligned.
        acc_shifted = (acc_q >> DIGIT)
                    | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        soma_d  = soma_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, FIM: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SOMA;
                end else begin
                    state_d = IDLE;
                end
            end
            SOMA: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_sum[DIGIT];
                acc_d   = acc_shifted;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_slice) begin
                    soma_d  = acc_shifted;
                    cout_d  = slice_sum[DIGIT];
                    // Carry into the MSB is a^b^sum at that bit; XOR with cout.
                    ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1]
                            ^ slice_sum[DIGIT-1] ^ slice_sum[DIGIT];
                    state_d = FIM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            soma_q  <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            soma_q  <= soma_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign soma     = soma_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == SOMA);
    assign done     = (state_q == FIM);

endmodule

// File: tb/tb_somador_serial.sv
// Bench for somador_serial: three instances (4/1, 8/4, 8/8), directed vectors
// plus random operands, checked against an integer-arithmetic model.
module tb_somador_serial;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start0, start1, start2;
    logic [3:0] a0, b0;
    logic [7:0] a1, b1, a2, b2;
    logic       cin0, cin1, cin2;
    logic [3:0] soma0;
    logic [7:0] soma1, soma2;
    logic       cout0, cout1, cout2, ovf0, ovf1, ovf2;
    logic       busy0, busy1, busy2, done0, done1, done2;

    somador_serial #(.WIDTH(4), .DIGIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
        .soma(soma0), .cout(cout0), .overflow(ovf0), .busy(busy0), .done(done0));
    somador_serial #(.WIDTH(8), .DIGIT(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .soma(soma1), .cout(cout1), .overflow(ovf1), .busy(busy1), .done(done1));
    somador_serial #(.WIDTH(8), .DIGIT(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .soma(soma2), .cout(cout2), .overflow(ovf2), .busy(busy2), .done(done2));

    int total = 0;
    int bad   = 0;

    logic [7:0] prev_s [3];
    logic       prev_c [3];
    logic       prev_o [3];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int sel);
        return (sel == 0) ? 4 : ((sel == 1) ? 2 : 1);
    endfunction

    // Reference: plain integer sum; signed overflow when both operands share a
    // sign that the result does not.
    function automatic void model(input int sel, input logic [7:0] av, input logic [7:0] bv,
                                  input logic ci, output logic [7:0] s,
                                  output logic c, output logic o);
        int w, x, y, sum, sx, sy, ss;
        w   = (sel == 0) ? 4 : 8;
        x   = int'(av) & ((1 << w) - 1);
        y   = int'(bv) & ((1 << w) - 1);
        sum = x + y + int'(ci);
        s   = 8'(sum & ((1 << w) - 1));
        c   = 1'((sum >> w) & 1);
        sx  = (x >> (w - 1)) & 1;
        sy  = (y >> (w - 1)) & 1;
        ss  = (sum >> (w - 1)) & 1;
        o   = (sx == sy) && (ss != sx);
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic ci);
        case (sel)
            0: begin start0 = st; a0 = av[3:0]; b0 = bv[3:0]; cin0 = ci; end
            1: begin start1 = st; a1 = av; b1 = bv; cin1 = ci; end
            default: begin start2 = st; a2 = av; b2 = bv; cin2 = ci; end
        endcase
    endtask

    task automatic sample(input int sel, output logic [7:0] s, output logic c,
                          output logic o, output logic bz, output logic dn);
        case (sel)
            0: begin s = {4'b0, soma0}; c = cout0; o = ovf0; bz = busy0; dn = done0; end
            1: begin s = soma1; c = cout1; o = ovf1; bz = busy1; dn = done1; end
            default: begin s = soma2; c = cout2; o = ovf2; bz = busy2; dn = done2; end
        endcase
    endtask

    // One full operation: accept, N busy cycles with junk on the inputs
    // (start included), done at edge N, done gone at edge N+1.
    task automatic do_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci);
        int n;
        logic [7:0] es, s;
        logic ec, eo, c, o, bz, dn;
        n = lat(sel);
        model(sel, av, bv, ci, es, ec, eo);
        drive(sel, 1'b1, av, bv, ci);
        @(posedge clk); #1;
        for (int k = 1; k <= n; k++) begin
            sample(sel, s, c, o, bz, dn);
            chk($sformatf("busy_soma%0d_k%0d", sel, k), 8'(bz), 8'd1);
            chk($sformatf("done_soma%0d_k%0d", sel, k), 8'(dn), 8'd0);
            chk($sformatf("hold_soma%0d_k%0d", sel, k), s, prev_s[sel]);
            chk($sformatf("hold_cout%0d_k%0d", sel, k), 8'(c), 8'(prev_c[sel]));
            chk($sformatf("hold_ovf%0d_k%0d", sel, k), 8'(o), 8'(prev_o[sel]));
            drive(sel, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk); #1;
        end
        sample(sel, s, c, o, bz, dn);
        chk($sformatf("done_rise%0d", sel), 8'(dn), 8'd1);
        chk($sformatf("busy_fim%0d", sel), 8'(bz), 8'd0);
        chk($sformatf("soma%0d_%0h_%0h_%0d", sel, av, bv, ci), s, es);
        chk($sformatf("cout%0d_%0h_%0h_%0d", sel, av, bv, ci), 8'(c), 8'(ec));
        chk($sformatf("ovf%0d_%0h_%0h_%0d", sel, av, bv, ci), 8'(o), 8'(eo));
        drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        @(posedge clk); #1;
        sample(sel, s, c, o, bz, dn);
        chk($sformatf("done_fall%0d", sel), 8'(dn), 8'd0);
        chk($sformatf("busy_idle%0d", sel), 8'(bz), 8'd0);
        chk($sformatf("soma_keep%0d", sel), s, es);
        prev_s[sel] = es;
        prev_c[sel] = ec;
        prev_o[sel] = eo;
    endtask

    initial begin
        logic [7:0] s, es;
        logic c, o, bz, dn, ec, eo;
        logic [7:0] qa [15];
        logic [7:0] qb [15];
        logic       qc [15];

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 8'h00, 8'h00, 1'b0);
            prev_s[i] = 8'h00; prev_c[i] = 1'b0; prev_o[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            sample(i, s, c, o, bz, dn);
            chk($sformatf("rst_soma%0d", i), s, 8'h00);
            chk($sformatf("rst_flags%0d", i), {4'b0, c, o, bz, dn}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        do_op(0, 8'd6, 8'd8, 1'b0);
        do_op(0, 8'd15, 8'd1, 1'b0);
        do_op(0, 8'd8, 8'd8, 1'b0);
        do_op(0, 8'd9, 8'd8, 1'b0);
        do_op(0, 8'd0, 8'd0, 1'b1);
        do_op(1, 8'h7F, 8'h01, 1'b0);
        do_op(2, 8'h7F, 8'h01, 1'b0);
        do_op(1, 8'hFF, 8'hFF, 1'b1);
        do_op(2, 8'h80, 8'h80, 1'b0);

        // Random operations on all configurations
        for (int i = 0; i < 12; i++)
            do_op(i % 3, 8'($urandom), 8'($urandom), 1'($urandom));

        // start held high, operands changing every cycle: accepted every N+1 edges
        for (int e = 0; e < 15; e++) begin
            qa[e] = 8'($urandom); qb[e] = 8'($urandom); qc[e] = 1'($urandom);
            drive(0, 1'b1, qa[e], qb[e], qc[e]);
            @(posedge clk); #1;
            sample(0, s, c, o, bz, dn);
            if (e % 5 == 4) begin
                model(0, qa[e-4], qb[e-4], qc[e-4], es, ec, eo);
                chk($sformatf("b2b_done_e%0d", e), 8'(dn), 8'd1);
                chk($sformatf("b2b_soma_e%0d", e), s, es);
                chk($sformatf("b2b_cout_e%0d", e), 8'(c), 8'(ec));
                chk($sformatf("b2b_ovf_e%0d", e), 8'(o), 8'(eo));
                prev_s[0] = es; prev_c[0] = ec; prev_o[0] = eo;
            end else begin
                chk($sformatf("b2b_nodone_e%0d", e), 8'(dn), 8'd0);
                chk($sformatf("b2b_busy_e%0d", e), 8'(bz), 8'd1);
                chk($sformatf("b2b_stable_e%0d", e), s, prev_s[0]);
            end
        end
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        sample(0, s, c, o, bz, dn);
        chk("b2b_end_done", 8'(dn), 8'd0);

        // Asynchronous reset mid-SOMA
        do_op(0, 8'd7, 8'd7, 1'b0);
        drive(0, 1'b1, 8'd3, 8'd4, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            sample(i, s, c, o, bz, dn);
            chk($sformatf("arst_soma%0d", i), s, 8'h00);
            chk($sformatf("arst_flags%0d", i), {4'b0, c, o, bz, dn}, 8'h00);
            prev_s[i] = 8'h00; prev_c[i] = 1'b0; prev_o[i] = 1'b0;
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            sample(0, s, c, o, bz, dn);
            chk($sformatf("arst_nodone_k%0d", k), {6'b0, bz, dn}, 8'h00);
            chk($sformatf("arst_zero_k%0d", k), s, 8'h00);
        end
        do_op(0, 8'd5, 8'd9, 1'b1);
        do_op(1, 8'($urandom), 8'($urandom), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/somador_serial.md
SOMADOR_SERIAL -- requirements
Module: somador_serial

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (>= 2).
REQ-002 The module SHALL have parameter DIGIT, default 1, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request a new addition; sampled on the rising edge of clk.
REQ-006 Port: a  input  WIDTH  operand A; sampled only on the edge that accepts start.
REQ-007 Port: b  input  WIDTH  operand B; sampled only on the edge that accepts start.
REQ-008 Port: cin  input  1  carry-in; sampled only on the edge that accepts start.
REQ-009 Port: soma  output  WIDTH  registered sum of the last completed operation.
REQ-010 Port: cout  output  1  registered unsigned carry-out of the last completed operation.
REQ-011 Port: overflow  output  1  registered two's-complement overflow of the last completed operation.
REQ-012 Port: busy  output  1  high while an addition is in progress.
REQ-013 Port: done  output  1  one-cycle pulse marking result update.

Function
REQ-014 The block SHALL implement FSM states IDLE, SOMA, FIM; N = WIDTH/DIGIT.
REQ-015 IDLE: on an edge with start=1, SHALL latch a, b, cin into internal registers, clear digit counter, enter SOMA; else stay.
REQ-016 SOMA: each edge SHALL add the next DIGIT-bit slice (LSB-first) of latched A and B plus the running carry, store the slice result internally, propagate carry, increment counter.
REQ-017 SOMA: on the edge processing slice N-1, SHALL update soma, cout, overflow together and enter FIM.
REQ-018 FIM: done=1 for that single cycle; next edge SHALL enter SOMA if start=1 (latching new operands, as REQ-015), else IDLE.
REQ-019 Latency: with start accepted at edge 0, soma/cout/overflow update and done rises at edge N; done falls at edge N+1.
REQ-020 busy SHALL be 1 exactly in state SOMA, done exactly in state FIM; both are registered state decodes, never combinational from start.
REQ-021 start asserted while in SOMA SHALL be ignored; operands SHALL not be re-sampled.
REQ-022 soma, cout, overflow SHALL hold the previous result, unchanged, throughout SOMA until the update edge of REQ-017; partial sums SHALL never appear on soma.
REQ-023 Arithmetic: {cout, soma} = A + B + cin modulo 2^(WIDTH+1); overflow = carry into bit WIDTH-1 XOR cout.
REQ-024 Operand changes on a, b, cin after the accepting edge SHALL not affect the result.
REQ-025 DIGIT = WIDTH SHALL yield N=1: result and done one edge after start acceptance.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state IDLE, counter 0, soma=0, cout=0, overflow=0, busy=0, done=0.
REQ-027 Reset asserted during SOMA SHALL abort the operation; no result update and no done pulse SHALL follow release.
REQ-028 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 WIDTH=4, DIGIT=1, cin=0: a=6, b=8 -> soma=1110, cout=0, overflow=0, done high exactly at edge 4 after acceptance, busy high during edges 1-4 cycles only.
REQ-030 WIDTH=4, DIGIT=1: (a=15,b=1) -> soma=0000,cout=1,overflow=0; (a=8,b=8) -> 0000,1,1; (a=9,b=8) -> 0001,1,1; (a=0,b=0,cin=1) -> 0001,0,0.
REQ-031 WIDTH=8, DIGIT=4: a=8'h7F, b=8'h01, cin=0 -> soma=8'h80, cout=0, overflow=1, done at edge 2; DIGIT=8 same operands -> done at edge 1.
REQ-032 Start held high continuously with operands changing every cycle -> back-to-back results for operands sampled only at IDLE/FIM acceptance edges; mid-SOMA operand values ignored; soma stable between done pulses.
REQ-033 rst_n pulsed low mid-SOMA (asynchronous, between edges) -> outputs zero immediately, no done pulse, subsequent start produces correct result with full latency N.
